// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: shares the write side of one single-clock FIFO among
// NUM_REQ requesters. Arbitration is round-robin and each grant is limited to
// MAX_BURST words. Data passes through combinationally, so an accepted word
// adds no latency.
// Optional feature macro: FIFO_ARB_LOCK_EN. When defined, it adds the req_lock
// input. A locked grant ignores the burst limit and is held until the requester
// drops valid or lock.
module fifo_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int REQ_BITS   = 2,
    parameter int MAX_BURST  = 4,
    parameter int BURST_BITS = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
`ifdef FIFO_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]            req_lock,
`endif
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic                          fifo_write_enable,
    output logic [REQ_BITS-1:0]           grant_id,
    output logic                          busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [REQ_BITS-1:0]   r_grant_id;
    logic [REQ_BITS-1:0]   w_grant_next;
    logic [REQ_BITS-1:0]   r_last_grant;
    logic [REQ_BITS-1:0]   w_last_next;
    logic [BURST_BITS-1:0] r_burst_cnt;
    logic [BURST_BITS-1:0] w_cnt_next;
    logic [BURST_BITS-1:0] w_cnt_upd;
    logic [REQ_BITS-1:0]   w_sel;
    logic                  w_any;
    logic                  w_valid_g;
    logic                  w_xfer;
    logic                  w_lock;
    logic                  w_release;

`ifdef FIFO_ARB_LOCK_EN
    assign w_lock = req_lock[r_grant_id];
`else
    assign w_lock = 1'b0;
`endif

    assign w_any     = |req_valid;
    assign w_valid_g = req_valid[r_grant_id];
    // A word is written only in GRANT, and never while reset is low, so
    // a burst cut short by reset does not write a partial word.
    assign w_xfer    = (r_state == GRANT) && reset && w_valid_g && !fifo_full;

    assign busy      = (r_state == GRANT);
    assign grant_id  = r_grant_id;
    assign fifo_data = req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH];

    // Round-robin pick: find the first valid requester after last_grant, wrapping around.
    always_comb begin : p_scan
        int idx;
        // NOTE: every combinational output gets a default before any branch,
        // otherwise a missed path would infer a latch.
        w_sel = '0;
        idx   = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(r_last_grant) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                w_sel = REQ_BITS'(idx);
            end
        end
    end

    // Burst counter advances per transfer and saturates at MAX_BURST. Release
    // happens on the burst limit (unless locked) or when the granted requester goes idle.
    always_comb begin
        w_cnt_upd = r_burst_cnt;
        if (w_xfer && (r_burst_cnt < BURST_BITS'(MAX_BURST))) begin
            w_cnt_upd = r_burst_cnt + BURST_BITS'(1);
        end
        w_release = !w_valid_g || (!w_lock && (w_cnt_upd >= BURST_BITS'(MAX_BURST)));
    end

    // Next-state logic for the IDLE/GRANT machine.
    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant_id;
        w_last_next  = r_last_grant;
        w_cnt_next   = r_burst_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_next = GRANT;
                    w_grant_next = w_sel;
                    w_cnt_next   = '0;
                end
            end
            GRANT: begin
                w_cnt_next = w_cnt_upd;
                if (w_release) begin
                    w_state_next = IDLE;
                    w_last_next  = r_grant_id;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Handshake outputs: only the granted requester is offered ready, and only when the FIFO has space.
    always_comb begin
        req_ready         = '0;
        fifo_write_enable = 1'b0;
        if ((r_state == GRANT) && reset) begin
            req_ready[r_grant_id] = !fifo_full;
            fifo_write_enable     = w_xfer;
        end
    end

    // State register with a synchronous active-low reset.
    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so all of them
        // update together from values sampled before the edge.
        if (!reset) begin
            r_state      <= IDLE;
            r_grant_id   <= '0;
            r_last_grant <= REQ_BITS'(NUM_REQ - 1);
            r_burst_cnt  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_grant_id   <= w_grant_next;
            r_last_grant <= w_last_next;
            r_burst_cnt  <= w_cnt_next;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter. A behavioural model, built from
// the arbitration rules, is compared with the DUT on every falling edge. This
// runs alongside directed scenarios that have literal expectations and a
// randomized soak.
`timescale 1ns/1ps
module tb_fifo_write_arbiter;

    localparam int DW = 32;
    localparam int N  = 4;
    localparam int RB = 2;
    localparam int MB = 4;
    localparam int BB = 3;

    logic            clock     = 1'b0;
    logic            reset     = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data  = '0;
    logic            fifo_full = 1'b0;
`ifdef FIFO_ARB_LOCK_EN
    logic [N-1:0]    req_lock  = '0;
`endif
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   fifo_data;
    logic            fifo_write_enable;
    logic [RB-1:0]   grant_id;
    logic            busy;

    always #5 clock = ~clock;

    fifo_write_arbiter #(
        .DATA_WIDTH(DW), .NUM_REQ(N), .REQ_BITS(RB), .MAX_BURST(MB), .BURST_BITS(BB)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_data         (req_data),
`ifdef FIFO_ARB_LOCK_EN
        .req_lock         (req_lock),
`endif
        .req_ready        (req_ready),
        .fifo_full        (fifo_full),
        .fifo_data        (fifo_data),
        .fifo_write_enable(fifo_write_enable),
        .grant_id         (grant_id),
        .busy             (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: whether a grant is open, which requester holds it,
    // who was granted last, and how many words this grant has taken.
    bit           m_known = 1'b0;
    bit           m_busy  = 1'b0;
    int           m_gid   = 0;
    int           m_last  = N - 1;
    int           m_cnt   = 0;
    logic [N-1:0] exp_ready_q = '0;

    // Logs of what the DUT actually wrote, used for the literal scenario checks.
    int       wlog[$];
    logic [DW-1:0] dlog[$];
    int       wcyc[$];
    int       blog[$];
    int       cur_len   = 0;
    bit       prev_busy = 1'b0;
    int       cyc       = 0;

    always @(negedge clock) begin : compare
        logic [N-1:0] e_ready;
        bit           e_we;
        bit           lk;
        bit           rel;
        e_ready = '0;
        e_we    = 1'b0;
        lk      = 1'b0;
        rel     = 1'b0;
        cyc++;
        if (m_known) begin
            if (reset && m_busy && !fifo_full) e_ready[m_gid] = 1'b1;
            e_we = reset && m_busy && req_valid[m_gid] && !fifo_full;
            check("busy", busy, m_busy);
            check("grant_id", grant_id, m_gid);
            check("req_ready", req_ready, e_ready);
            check("fifo_write_enable", fifo_write_enable, e_we);
            if (m_busy) check("fifo_data", fifo_data, req_data[m_gid*DW +: DW]);
        end
        exp_ready_q = e_ready;

        if (fifo_write_enable === 1'b1) begin
            wlog.push_back(int'(grant_id));
            dlog.push_back(fifo_data);
            wcyc.push_back(cyc);
            cur_len++;
        end
        if (prev_busy && (busy !== 1'b1)) begin
            blog.push_back(cur_len);
            cur_len = 0;
        end
        prev_busy = (busy === 1'b1);

        // Advance the model to what the next rising edge must produce.
        if (!reset) begin
            m_known = 1'b1;
            m_busy  = 1'b0;
            m_gid   = 0;
            m_last  = N - 1;
            m_cnt   = 0;
        end else if (m_known) begin
            if (!m_busy) begin
                for (int k = 1; k <= N; k++) begin
                    if (!m_busy && req_valid[(m_last + k) % N]) begin
                        m_busy = 1'b1;
                        m_gid  = (m_last + k) % N;
                        m_cnt  = 0;
                    end
                end
            end else begin
`ifdef FIFO_ARB_LOCK_EN
                lk = req_lock[m_gid];
`endif
                if (e_we && m_cnt < MB) m_cnt++;
                rel = !req_valid[m_gid] || (!lk && m_cnt >= MB);
                if (rel) begin
                    m_busy = 1'b0;
                    m_last = m_gid;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        int k = 0;
        while (wlog.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(name, wlog.size() >= n, 1);
    endtask

    task automatic go_idle();
        req_valid = '0;
        fifo_full = 1'b0;
        repeat (3) tick();
    endtask

    int rr_order [5] = '{0, 1, 2, 3, 0};

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [N-1:0] acc;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 32'hD000_0000 + i;

        // Reset held with every requester valid: nothing may be granted or written.
        reset     = 1'b0;
        req_valid = '1;
        repeat (3) tick();
        at_sample();
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);
        check("rst_we", fifo_write_enable, 0);
        check("rst_writes", wlog.size(), 0);
        tick();

        // Round-robin with all requesters valid: bursts of 4 in order 0,1,2,3,0.
        wlog.delete(); dlog.delete(); wcyc.delete(); blog.delete();
        reset = 1'b1;
        repeat (26) tick();
        check("rr_count", wlog.size() >= 20, 1);
        if (wlog.size() >= 20) begin
            for (int b = 0; b < 5; b++)
                for (int w = 0; w < 4; w++)
                    check($sformatf("rr_b%0d_w%0d", b, w), wlog[4*b + w], rr_order[b]);
            check("rr_data_b1", dlog[4], 32'hD000_0001);
            check("rr_data_b3", dlog[12], 32'hD000_0003);
            check("rr_burst_span", wcyc[3] - wcyc[0], 3);
            check("rr_idle_gap", wcyc[4] - wcyc[3], 2);
        end
        check("rr_blen_count", blog.size() >= 4, 1);
        if (blog.size() >= 4)
            for (int b = 0; b < 4; b++) check($sformatf("rr_blen%0d", b), blog[b], 4);

        // Early release: requester 2 gives two words, then drops valid.
        go_idle();
        wlog.delete();
        req_valid = 4'b0100;
        wait_writes(2, 20, "early_two_words");
        req_valid = 4'b1011;
        repeat (8) tick();
        check("early_count", wlog.size() >= 3, 1);
        if (wlog.size() >= 3) begin
            check("early_w0", wlog[0], 2);
            check("early_w1", wlog[1], 2);
            check("early_next", wlog[2], 3);
        end

        // Backpressure: FIFO full for 3 cycles in the middle of requester 1's burst.
        go_idle();
        wlog.delete(); blog.delete();
        req_valid = 4'b0010;
        wait_writes(2, 20, "bp_two_words");
        fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            at_sample();
            check($sformatf("bp_ready_%0d", c), req_ready, 0);
            check($sformatf("bp_we_%0d", c), fifo_write_enable, 0);
            tick();
        end
        fifo_full = 1'b0;
        begin
            int k = 0;
            while (blog.size() < 1 && k < 20) begin
                tick();
                k++;
            end
        end
        check("bp_burst_done", blog.size() >= 1, 1);
        if (blog.size() >= 1) check("bp_burst_len", blog[0], 4);

        // Reset in the middle of a burst, after its second word.
        go_idle();
        wlog.delete();
        req_valid = '1;
        wait_writes(2, 20, "mr_two_words");
        reset = 1'b0;
        wlog.delete();
        at_sample();
        check("mr_we", fifo_write_enable, 0);
        check("mr_ready", req_ready, 0);
        tick();
        at_sample();
        check("mr_busy", busy, 0);
        tick();
        check("mr_no_writes", wlog.size(), 0);
        reset = 1'b1;
        repeat (6) tick();
        check("mr_restart_count", wlog.size() >= 1, 1);
        if (wlog.size() >= 1) check("mr_restart_id", wlog[0], 0);

`ifdef FIFO_ARB_LOCK_EN
        // Locked grant: requester 3 writes 10 words without release, then drops the lock.
        go_idle();
        wlog.delete(); blog.delete();
        req_lock  = 4'b1000;
        req_valid = 4'b1000;
        wait_writes(10, 40, "lock_ten_words");
        at_sample();
        check("lock_still_busy", busy, 1);
        tick();
        fifo_full = 1'b1;
        req_lock  = '0;
        tick();
        at_sample();
        check("lock_released", busy, 0);
        check("lock_blog", blog.size(), 1);
        if (blog.size() >= 1) check("lock_burst_len", blog[0], 11);
        fifo_full = 1'b0;
        req_valid = '0;
        tick();
`endif

        // Randomized soak against the model, following the requester protocol.
        for (int c = 0; c < 3000; c++) begin
            acc = exp_ready_q & req_valid;
            for (int i = 0; i < N; i++) begin
                if (acc[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 9) < 6);
                    req_data[i*DW +: DW] = $urandom();
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
`ifdef FIFO_ARB_LOCK_EN
                if ($urandom_range(0, 7) == 0) req_lock[i] = ~req_lock[i];
`endif
            end
            fifo_full = ($urandom_range(0, 4) == 0);
            reset     = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
